// File: rtl/csa_parameterized_pkg.sv
// Carry-save adder helpers.
// Holds the single-bit full-adder equations so that the cell and any future
// users share one definition. No constants live here: the operand width is a
// parameter of csa_parameterized.
package csa_parameterized_pkg;

  // Sum output of a 3:2 compressor cell.
  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  // Carry output of a 3:2 compressor cell (majority of the three inputs).
  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (b & c) | (a & c);
  endfunction

endpackage

// File: rtl/csa_parameterized_fa_cell.sv
// csa_fa_cell: one bit of the carry-save stage, a plain full adder.
// Ports:
//   a, b, c : the three input bits of one column
//   s       : column sum bit
//   co      : column carry bit (weight 2, left unshifted for the caller)
module csa_fa_cell
  import csa_parameterized_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  always_comb begin
    s  = fa_sum(a, b, c);
    co = fa_carry(a, b, c);
  end

endmodule

// File: rtl/csa_parameterized.sv
// csa_parameterized: registered 3-operand carry-save adder with a resolving
// adder behind it.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   in_valid  : qualifies A/B/Cin on this edge
//   A, B, Cin : three unsigned WIDTH-bit operands
//   Sum       : registered carry-save sum vector
//   Cout      : registered carry-save carry vector (unshifted)
//   Total     : registered Sum + (Cout << 1), WIDTH+2 bits
//   out_valid : registered in_valid
module csa_parameterized #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] Cin,
  output logic [WIDTH-1:0] Sum,
  output logic [WIDTH-1:0] Cout,
  output logic [WIDTH+1:0] Total,
  output logic             out_valid
);

  logic [WIDTH-1:0] sum_w;
  logic [WIDTH-1:0] cout_w;
  logic [WIDTH+1:0] total_w;

  logic [WIDTH-1:0] sum_d,  sum_q;
  logic [WIDTH-1:0] cout_d, cout_q;
  logic [WIDTH+1:0] total_d, total_q;
  logic             out_valid_d, out_valid_q;

  // Independent columns: no carry ripples between cells.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    csa_fa_cell u_cell (
      .a  (A[i]),
      .b  (B[i]),
      .c  (Cin[i]),
      .s  (sum_w[i]),
      .co (cout_w[i])
    );
  end

  // Carry vector carries weight 2, hence the shift; WIDTH+2 bits hold
  // 3*(2^WIDTH-1) without truncation.
  always_comb begin
    total_w = {2'b00, sum_w} + {1'b0, cout_w, 1'b0};
  end

  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    total_d     = total_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      sum_d   = sum_w;
      cout_d  = cout_w;
      total_d = total_w;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q       <= '0;
      cout_q      <= '0;
      total_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      total_q     <= total_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Total     = total_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_csa_parameterized.sv
// Bench for csa_parameterized at WIDTH = 1, 4 and 16 driven from one shared
// 16-bit stimulus (narrow instances see the low bits). Expected results are
// queued at issue time and checked by an independent monitor.
module tb_csa_parameterized;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] a_s, b_s, c_s;

  logic        sum1, cout1, ov1;
  logic [2:0]  tot1;
  logic [3:0]  sum4, cout4;
  logic [5:0]  tot4;
  logic        ov4;
  logic [15:0] sum16, cout16;
  logic [17:0] tot16;
  logic        ov16;

  csa_parameterized #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .A(a_s[0:0]), .B(b_s[0:0]), .Cin(c_s[0:0]),
    .Sum(sum1), .Cout(cout1), .Total(tot1), .out_valid(ov1)
  );

  csa_parameterized #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .A(a_s[3:0]), .B(b_s[3:0]), .Cin(c_s[3:0]),
    .Sum(sum4), .Cout(cout4), .Total(tot4), .out_valid(ov4)
  );

  csa_parameterized #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .A(a_s), .B(b_s), .Cin(c_s),
    .Sum(sum16), .Cout(cout16), .Total(tot16), .out_valid(ov16)
  );

  // Zero-extended views so all instances are compared uniformly.
  logic [15:0] sum_o  [3];
  logic [15:0] cout_o [3];
  logic [17:0] tot_o  [3];
  logic        ov_o   [3];
  assign sum_o[0]  = {15'b0, sum1};
  assign sum_o[1]  = {12'b0, sum4};
  assign sum_o[2]  = sum16;
  assign cout_o[0] = {15'b0, cout1};
  assign cout_o[1] = {12'b0, cout4};
  assign cout_o[2] = cout16;
  assign tot_o[0]  = {15'b0, tot1};
  assign tot_o[1]  = {12'b0, tot4};
  assign tot_o[2]  = tot16;
  assign ov_o[0]   = ov1;
  assign ov_o[1]   = ov4;
  assign ov_o[2]   = ov16;

  typedef struct packed {
    logic [2:0][15:0] s;
    logic [2:0][15:0] c;
    logic [2:0][17:0] t;
  } exp_t;

  exp_t sb[$];
  exp_t hold_e;
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference: each column counts its ones (sum = LSB of the count, carry =
  // count >= 2); Total is the plain arithmetic sum of the masked operands.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] c);
    exp_t        e;
    int          w;
    int          cnt;
    logic [15:0] m;
    e = '0;
    for (int k = 0; k < 3; k++) begin
      w = (k == 0) ? 1 : (k == 1) ? 4 : 16;
      m = (w == 16) ? 16'hFFFF : 16'((32'd1 << w) - 1);
      for (int i = 0; i < w; i++) begin
        cnt = int'(a[i]) + int'(b[i]) + int'(c[i]);
        e.s[k][i] = (cnt % 2) == 1;
        e.c[k][i] = (cnt >= 2);
      end
      e.t[k] = 18'(a & m) + 18'(b & m) + 18'(c & m);
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_sum_w%0d", tag, k),   32'(sum_o[k]),  32'd0);
      check($sformatf("%s_cout_w%0d", tag, k),  32'(cout_o[k]), 32'd0);
      check($sformatf("%s_total_w%0d", tag, k), 32'(tot_o[k]),  32'd0);
      check($sformatf("%s_ovalid_w%0d", tag, k), 32'(ov_o[k]),  32'd0);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] c);
    @(posedge clk);
    #1;
    in_valid = v;
    a_s = a;
    b_s = b;
    c_s = c;
    if (v) sb.push_back(model(a, b, c));
  endtask

  // Monitor: pops one expectation per presented result; otherwise the
  // outputs must be holding the last result (or zero after reset).
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_e = '0;
    end else if (ov1 | ov4 | ov16) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", {29'b0, ov1, ov4, ov16}, 32'd0);
      end else begin
        e = sb.pop_front();
        for (int k = 0; k < 3; k++) begin
          check($sformatf("ovalid_w%0d", k), 32'(ov_o[k]), 32'd1);
          check($sformatf("sum_w%0d", k),    32'(sum_o[k]),  32'(e.s[k]));
          check($sformatf("cout_w%0d", k),   32'(cout_o[k]), 32'(e.c[k]));
          check($sformatf("total_w%0d", k),  32'(tot_o[k]),  32'(e.t[k]));
        end
        hold_e = e;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("hold_sum_w%0d", k),   32'(sum_o[k]),  32'(hold_e.s[k]));
        check($sformatf("hold_cout_w%0d", k),  32'(cout_o[k]), 32'(hold_e.c[k]));
        check($sformatf("hold_total_w%0d", k), 32'(tot_o[k]),  32'(hold_e.t[k]));
      end
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a_s      = '0;
    b_s      = '0;
    c_s      = '0;
    repeat (2) @(posedge clk);
    #2;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed 4-bit cases, including the maximum.
    drive(1'b1, 16'h000B, 16'h000D, 16'h0006);
    drive(1'b1, 16'h000F, 16'h000F, 16'h0007);
    drive(1'b1, 16'h0001, 16'h0002, 16'h0001);
    drive(1'b1, 16'h000F, 16'h000F, 16'h000F);
    drive(1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    drive(1'b1, 16'h0000, 16'h0000, 16'h0000);

    // Load a result, then present new operands without in_valid.
    drive(1'b1, 16'h5A3C, 16'h0F0F, 16'h1234);
    for (int i = 0; i < 3; i++)
      drive(1'b0, 16'($urandom), 16'($urandom), 16'($urandom));

    // Randomized traffic, mostly back-to-back.
    for (int i = 0; i < 200; i++)
      drive(($urandom_range(0, 9) < 7), 16'($urandom), 16'($urandom), 16'($urandom));

    // Reset between edges with a result loaded and another pending.
    drive(1'b1, 16'hFFFF, 16'hFFFE, 16'h8001);
    drive(1'b1, 16'h7777, 16'h3333, 16'h1111);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check_zero("async_rst");
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // First valid after reset produces a result one cycle later.
    drive(1'b1, 16'hABCD, 16'h1357, 16'h2468);
    for (int i = 0; i < 100; i++)
      drive(($urandom_range(0, 9) < 8), 16'($urandom), 16'($urandom), 16'($urandom));

    drive(1'b0, 16'h0, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
